// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Purpose:
//   Arbitrates NUM_REQ writeback requesters (ALU, load unit, CSR unit, ...)
//   onto the register file's single write port. It also keeps a 32-entry busy
//   scoreboard so the issue stage can stall on RAW hazards and is refused on
//   WAW hazards.
//
// Configuration macro:
//   WB_ROUND_ROBIN_EN - when defined, round-robin arbitration starting at a
//                       rotating pointer. When undefined, fixed priority with
//                       the lowest index winning, and no pointer register.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   wb_valid/rd/data  per-requester writeback requests (packed, requester i
//                     at rd[5i+4:5i] and data[XLEN*i +: XLEN])
//   wb_ready          one-hot grant (combinational)
//   rf_we/waddr/wdata registered register-file write port
//   issue_valid/rd    issuing instruction and its destination
//   issue_ready       issue accepted this cycle (combinational)
//   query_rs1/rs2     source indices for hazard checks
//   rs1_busy/rs2_busy combinational busy flags for the queried sources
//   busy_count        registered popcount of the scoreboard
// -----------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      wb_valid,
  input  logic [NUM_REQ*5-1:0]    wb_rd,
  input  logic [NUM_REQ*XLEN-1:0] wb_data,
  output logic [NUM_REQ-1:0]      wb_ready,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [XLEN-1:0]         rf_wdata,
  input  logic                    issue_valid,
  input  logic [4:0]              issue_rd,
  output logic                    issue_ready,
  input  logic [4:0]              query_rs1,
  input  logic [4:0]              query_rs2,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [5:0]              busy_count
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [31:0]     busy_q;
  logic [31:0]     busy_d;
  logic [5:0]      count_d;
  logic            gnt_any;
  logic [IDXW-1:0] gnt_idx;
  logic [4:0]      gnt_rd;
  logic [XLEN-1:0] gnt_data;

  // ---------------------------------------------------------------------------
  // Grant selection
  // ---------------------------------------------------------------------------
`ifdef WB_ROUND_ROBIN_EN
  logic [IDXW-1:0] ptr_q;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && wb_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'(idx);
      end
    end
  end
`else
  // Fixed priority: scanning downward lets the lowest valid index win.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (wb_valid[i]) begin
        gnt_any = 1'b1;
        gnt_idx = IDXW'(i);
      end
    end
  end
`endif

  assign gnt_rd   = wb_rd[5*int'(gnt_idx) +: 5];
  assign gnt_data = wb_data[XLEN*int'(gnt_idx) +: XLEN];

  // All combinational outputs are forced low while reset is held.
  always_comb begin
    wb_ready = '0;
    if (gnt_any && !reset) wb_ready[gnt_idx] = 1'b1;
  end

  // busy_q[0] is never set, so issue to x0 is always accepted and queries of
  // x0 always read as not busy.
  assign issue_ready = !reset && issue_valid && !busy_q[issue_rd];
  assign rs1_busy    = !reset && busy_q[query_rs1];
  assign rs2_busy    = !reset && busy_q[query_rs2];

  // ---------------------------------------------------------------------------
  // Scoreboard next state. The clear happens at the end of the grant cycle so
  // a reader unblocked in t+1 sees the register file already written in t+2.
  // The set is applied after the clear: a fresh issue to a register that is
  // not busy but is being written back this cycle must stay marked.
  // ---------------------------------------------------------------------------
  always_comb begin
    busy_d = busy_q;
    if (gnt_any)     busy_d[gnt_rd]   = 1'b0;
    if (issue_ready) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;

    count_d = '0;
    for (int i = 0; i < 32; i++) count_d = count_d + 6'(busy_d[i]);
  end

  // ---------------------------------------------------------------------------
  // State and registered outputs
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q     <= '0;
      busy_count <= '0;
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
`ifdef WB_ROUND_ROBIN_EN
      ptr_q      <= '0;
`endif
    end else begin
      busy_q     <= busy_d;
      busy_count <= count_d;
      // A grant to x0 is consumed but never reaches the register file.
      rf_we      <= gnt_any && (gnt_rd != 5'd0);
      if (gnt_any) begin
        rf_waddr <= gnt_rd;
        rf_wdata <= gnt_data;
`ifdef WB_ROUND_ROBIN_EN
        ptr_q    <= (gnt_idx == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx + IDXW'(1);
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for regfile_wb_scheduler (NUM_REQ=3, XLEN=32).
// Vectors carry inputs plus expected combinational outputs for that cycle and
// the expected busy_count after the edge. Expected writes are queued when a
// grant is expected and compared against the register-file port one cycle on.
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;
  localparam int NUM_REQ = 3;
  localparam int XLEN    = 32;

  logic                    clk;
  logic                    reset;
  logic [NUM_REQ-1:0]      wb_valid;
  logic [NUM_REQ*5-1:0]    wb_rd;
  logic [NUM_REQ*XLEN-1:0] wb_data;
  logic [NUM_REQ-1:0]      wb_ready;
  logic                    rf_we;
  logic [4:0]              rf_waddr;
  logic [XLEN-1:0]         rf_wdata;
  logic                    issue_valid;
  logic [4:0]              issue_rd;
  logic                    issue_ready;
  logic [4:0]              query_rs1;
  logic [4:0]              query_rs2;
  logic                    rs1_busy;
  logic                    rs2_busy;
  logic [5:0]              busy_count;

  regfile_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .wb_ready    (wb_ready),
    .rf_we       (rf_we),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .query_rs1   (query_rs1),
    .query_rs2   (query_rs2),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy),
    .busy_count  (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  valid;
    logic [4:0]  rd0, rd1, rd2;
    logic [31:0] d0, d1, d2;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  q1, q2;
    logic [2:0]  e_ready;
    logic        e_iready;
    logic        e_b1, e_b2;
    logic [5:0]  e_cnt;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t  exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_no = 0;
  vec_t tbl[16];

  function automatic vec_t mk(
    input logic [2:0] valid,
    input logic [4:0] rd0, input logic [31:0] d0,
    input logic [4:0] rd1, input logic [31:0] d1,
    input logic [4:0] rd2, input logic [31:0] d2,
    input logic iv, input logic [4:0] ird,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic [2:0] e_ready, input logic e_iready,
    input logic e_b1, input logic e_b2, input logic [5:0] e_cnt);
    vec_t v;
    v.valid = valid; v.rd0 = rd0; v.d0 = d0; v.rd1 = rd1; v.d1 = d1;
    v.rd2 = rd2; v.d2 = d2; v.iv = iv; v.ird = ird; v.q1 = q1; v.q2 = q2;
    v.e_ready = e_ready; v.e_iready = e_iready; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (vec %0d): got %h expected %h", name, vec_no, act, exp);
    end
  endtask

  // Compare the write port against the oldest queued expectation, or require
  // rf_we low when nothing was granted.
  task automatic check_write();
    wr_t w;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check("rf_we", 32'(rf_we), 32'd1);
      check("rf_waddr", 32'(rf_waddr), 32'(w.rd));
      check("rf_wdata", rf_wdata, w.data);
    end else begin
      check("rf_we idle", 32'(rf_we), 32'd0);
    end
  endtask

  // Drive one cycle of stimulus shortly after a rising edge, check the
  // combinational outputs, then check the registered outputs after the edge.
  task automatic apply_vec(input vec_t v);
    wr_t w;
    wb_valid    = v.valid;
    wb_rd       = {v.rd2, v.rd1, v.rd0};
    wb_data     = {v.d2, v.d1, v.d0};
    issue_valid = v.iv;
    issue_rd    = v.ird;
    query_rs1   = v.q1;
    query_rs2   = v.q2;
    #1;
    check("wb_ready", 32'(wb_ready), 32'(v.e_ready));
    check("issue_ready", 32'(issue_ready), 32'(v.e_iready));
    check("rs1_busy", 32'(rs1_busy), 32'(v.e_b1));
    check("rs2_busy", 32'(rs2_busy), 32'(v.e_b2));
    w.rd = 5'd0;
    w.data = 32'd0;
    case (v.e_ready)
      3'b001:  begin w.rd = v.rd0; w.data = v.d0; end
      3'b010:  begin w.rd = v.rd1; w.data = v.d1; end
      3'b100:  begin w.rd = v.rd2; w.data = v.d2; end
      default: ;
    endcase
    if (w.rd != 5'd0) exp_q.push_back(w);
    @(posedge clk);
    #1;
    check_write();
    check("busy_count", 32'(busy_count), 32'(v.e_cnt));
    vec_no++;
  endtask

  initial begin
    // Reset with busy inputs: every combinational output must be held low.
    reset       = 1'b1;
    wb_valid    = 3'b111;
    wb_rd       = {5'd3, 5'd2, 5'd1};
    wb_data     = {32'h3, 32'h2, 32'h1};
    issue_valid = 1'b1;
    issue_rd    = 5'd5;
    query_rs1   = 5'd5;
    query_rs2   = 5'd1;
    repeat (2) @(posedge clk);
    #1;
    check("reset wb_ready", 32'(wb_ready), 32'd0);
    check("reset issue_ready", 32'(issue_ready), 32'd0);
    check("reset rs1_busy", 32'(rs1_busy), 32'd0);
    check("reset rs2_busy", 32'(rs2_busy), 32'd0);
    check("reset rf_we", 32'(rf_we), 32'd0);
    check("reset rf_waddr", 32'(rf_waddr), 32'd0);
    check("reset rf_wdata", rf_wdata, 32'd0);
    check("reset busy_count", 32'(busy_count), 32'd0);
    reset = 1'b0;

    //          valid   rd0 d0              rd1 d1              rd2 d2        iv ird q1 q2  ready  ir b1 b2 cnt
    tbl[0]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         0, 0,  0, 0,  3'b000, 0, 0, 0, 0);
    tbl[1]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         1, 5,  5, 0,  3'b000, 1, 0, 0, 1);
    tbl[2]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         0, 0,  5, 0,  3'b000, 0, 1, 0, 1);
    tbl[3]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         1, 5,  5, 0,  3'b000, 0, 1, 0, 1);
    tbl[4]  = mk(3'b010, 0, 0,              5, 32'hDEADBEEF,   0, 0,         0, 0,  5, 0,  3'b010, 0, 1, 0, 0);
    tbl[5]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         0, 0,  5, 0,  3'b000, 0, 0, 0, 0);
    tbl[6]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         1, 7,  7, 0,  3'b000, 1, 0, 0, 1);
    tbl[7]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         1, 3,  7, 3,  3'b000, 1, 1, 0, 2);
    tbl[8]  = mk(3'b001, 7, 32'h77,         0, 0,              0, 0,         1, 7,  7, 3,  3'b001, 0, 1, 1, 1);
    tbl[9]  = mk(3'b000, 0, 0,              0, 0,              0, 0,         1, 7,  7, 3,  3'b000, 1, 0, 1, 2);
    tbl[10] = mk(3'b000, 0, 0,              0, 0,              0, 0,         0, 0,  7, 3,  3'b000, 0, 1, 1, 2);
    tbl[11] = mk(3'b001, 0, 32'h1234,       0, 0,              0, 0,         0, 0,  0, 0,  3'b001, 0, 0, 0, 2);
    tbl[12] = mk(3'b100, 0, 0,              0, 0,              9, 32'h99,    0, 0,  9, 0,  3'b100, 0, 0, 0, 2);
    tbl[13] = mk(3'b010, 0, 0,              3, 32'h33,         0, 0,         1, 12, 3, 12, 3'b010, 1, 1, 0, 2);
    tbl[14] = mk(3'b000, 0, 0,              0, 0,              0, 0,         0, 0,  3, 12, 3'b000, 0, 0, 1, 2);
    tbl[15] = mk(3'b000, 0, 0,              0, 0,              0, 0,         1, 0,  0, 0,  3'b000, 1, 0, 0, 2);

    for (int i = 0; i < 16; i++) apply_vec(tbl[i]);

    // Reset mid-operation: x7, x12 busy already; mark x3 and x9 too.
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 3'b000, 1, 0, 0, 3));
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 9, 3, 0, 3'b000, 1, 1, 0, 4));
    reset       = 1'b1;
    wb_valid    = 3'b001;
    wb_rd       = {5'd0, 5'd0, 5'd3};
    wb_data     = {32'h0, 32'h0, 32'h55};
    issue_valid = 1'b1;
    issue_rd    = 5'd20;
    query_rs1   = 5'd3;
    query_rs2   = 5'd9;
    #1;
    check("midreset wb_ready", 32'(wb_ready), 32'd0);
    check("midreset issue_ready", 32'(issue_ready), 32'd0);
    check("midreset rs1_busy", 32'(rs1_busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset rf_we", 32'(rf_we), 32'd0);
    check("midreset busy_count", 32'(busy_count), 32'd0);
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 3, 9, 3'b000, 0, 0, 0, 0));

    // Three requesters contend; each drops after its grant.
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 10, 0, 0, 3'b000, 1, 0, 0, 1));
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 11, 0, 0, 3'b000, 1, 0, 0, 2));
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 1, 12, 0, 0, 3'b000, 1, 0, 0, 3));
    apply_vec(mk(3'b111, 10, 32'hA0, 11, 32'hB0, 12, 32'hC0, 0, 0, 10, 11, 3'b001, 0, 1, 1, 2));
    apply_vec(mk(3'b110, 10, 32'hA0, 11, 32'hB0, 12, 32'hC0, 0, 0, 10, 11, 3'b010, 0, 0, 1, 1));
    apply_vec(mk(3'b100, 10, 32'hA0, 11, 32'hB0, 12, 32'hC0, 0, 0, 10, 11, 3'b100, 0, 0, 0, 0));

    // Requester 0 keeps requesting with new data while requester 1 waits.
    apply_vec(mk(3'b011, 13, 32'hA1, 14, 32'hB1, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0));
`ifdef WB_ROUND_ROBIN_EN
    apply_vec(mk(3'b011, 13, 32'hA2, 14, 32'hB1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));
    apply_vec(mk(3'b001, 13, 32'hA2, 14, 32'hB1, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0));
`else
    apply_vec(mk(3'b011, 13, 32'hA2, 14, 32'hB1, 0, 0, 0, 0, 0, 0, 3'b001, 0, 0, 0, 0));
    apply_vec(mk(3'b010, 13, 32'hA2, 14, 32'hB1, 0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0));
`endif
    apply_vec(mk(3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0));

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover writes: got %0d expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_scheduler.md
Name: regfile_wb_scheduler

Overview:
Shares the register file's single write port among NUM_REQ writeback requesters (ALU, load unit, CSR unit) using valid/ready handshakes and an arbitration policy.
Keeps a 32-entry busy scoreboard: a bit is set when an instruction issues with a destination register and cleared when that register's write commits.
Source-register queries return busy flags so the issue stage can stall on RAW hazards. Issue is refused while the destination is already busy, which blocks WAW hazards.
Sits between the execute/writeback units and the register file's write port (write enable, write address, write data).

Parameters:
NUM_REQ, 3, number of writeback requesters; legal range 2..8.
XLEN, 32, data width of the write port.

Ports:
clk  in  1  system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
wb_valid  in  NUM_REQ  per-requester writeback request.
wb_rd  in  NUM_REQ*5  per-requester destination index; requester i occupies bits [5i+4:5i].
wb_data  in  NUM_REQ*XLEN  per-requester write data; requester i occupies bits [XLEN*i+XLEN-1:XLEN*i].
wb_ready  out  NUM_REQ  one-hot grant; combinational from wb_valid and arbiter state.
rf_we  out  1  register file write enable; registered.
rf_waddr  out  5  register file write address; registered.
rf_wdata  out  XLEN  register file write data; registered.
issue_valid  in  1  issue stage presents an instruction.
issue_rd  in  5  destination of the issuing instruction.
issue_ready  out  1  issue accepted this cycle; combinational.
query_rs1  in  5  source 1 index for hazard check.
query_rs2  in  5  source 2 index for hazard check.
rs1_busy  out  1  combinational busy flag for query_rs1.
rs2_busy  out  1  combinational busy flag for query_rs2.
busy_count  out  6  number of busy registers (0..31); registered.

Behaviour:
- Reset (synchronous): scoreboard cleared; rf_we=0, rf_waddr=0, rf_wdata=0; busy_count=0; round-robin pointer=0.
- While reset is high, all combinational outputs are forced low: wb_ready=0, issue_ready=0, rs1_busy=0, rs2_busy=0.
- Arbitration:
  - At most one wb_ready bit is high per cycle, and only for a requester whose wb_valid is high.
  - A transfer occurs when wb_valid[i] and wb_ready[i] are both high.
  - A requester holds wb_valid, wb_rd and wb_data stable until granted.
- Write latency:
  - A grant in cycle t produces rf_we=1 in cycle t+1, with rf_waddr and rf_wdata taken from the granted requester.
  - rf_we=0 in any cycle following a cycle with no grant. rf_waddr and rf_wdata hold their last values.
  - The register file performs the write at the end of cycle t+1; data is readable from cycle t+2.
- x0 handling:
  - A granted request with wb_rd=0 is consumed (wb_ready high) but produces rf_we=0.
  - x0 is never marked busy. rs*_busy is always 0 for index 0.
- Scoreboard set:
  - issue_ready = issue_valid && !busy[issue_rd].
  - When issue_ready is high, busy[issue_rd] is set at the clock edge. issue_rd=0 is accepted and leaves the scoreboard unchanged.
- Scoreboard clear:
  - busy[wb_rd] is cleared at the edge that ends the grant cycle t, not the rf_we cycle. The flag is therefore already clear in cycle t+1.
  - Consequence: a reader unblocked in t+1 reads the register file in t+1, and its registered read data appears in t+2, after the write has landed.
- Simultaneous events:
  - If an issue and a grant target the same register in the same cycle, issue_ready is 0, because busy is evaluated before the clear.
  - Issue may re-mark the register from cycle t+1 onward.
- A writeback to a register that is not busy is still written. The scoreboard is unchanged and no error is flagged.
- busy_count is registered and equals popcount(busy) after each edge. Incrementing and decrementing in the same cycle leaves the count unchanged.
- Reset asserted mid-operation: a pending grant is discarded, rf_we is 0 on the next cycle, and the scoreboard is fully cleared.

Optional Feature:
Macro: WB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. The pointer advances to (granted index + 1) mod NUM_REQ after each grant; the search starts at the pointer. No requester waits more than NUM_REQ-1 grants.
- Undefined: fixed priority with the lowest index winning. The pointer register is not instantiated.

Test Plan:
- Reset then idle: all outputs 0; issue rd=5 → issue_ready=1, next cycle rs1_busy=1 with query_rs1=5, busy_count=1.
- Issue rd=5; requester 1 writes rd=5, data=0xDEADBEEF at cycle t → wb_ready=3'b010 at t; rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1; rs1_busy=0 at t+1.
- Requesters 0, 1 and 2 all valid for 3 cycles with WB_ROUND_ROBIN_EN defined → grants 0, 1, 2. Without the macro → grants 0, then 1 (after 0 drops), then 2.
- Issue rd=7 in the same cycle as a grant for rd=7 → issue_ready=0; retry next cycle → issue_ready=1 and busy[7]=1.
- Requester 0 writes rd=0, data=0x1234 → wb_ready[0]=1, rf_we stays 0, busy_count unchanged.
- Mark rd=3 and rd=9 busy, then assert reset for 1 cycle during an active grant → next cycle rf_we=0, busy_count=0, rs1_busy=0.
